// File: rtl/risc_sequencer_pkg.sv
// Shared opcode and phase encodings for the 8-bit RISC core (decoder, ALU, sequencer).
package risc_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_sequencer_phase_counter.sv
// Free-running 3-bit instruction phase counter; hold freezes it, reset forces phase 0.
module phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [2:0] phase
);

  always_ff @(posedge clk) begin
    if (!rst)
      phase <= 3'd0;
    else if (!hold)
      phase <= phase + 3'd1;
  end

endmodule

// File: rtl/risc_sequencer.sv
// Instruction sequencer: phase counter plus combinational control decode and halt latch.
module risc_sequencer
  import risc_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt
);

  logic halted;
  logic hlt_now;
  logic alu;

  // HLT seen in OP_ADDR: freeze the phase on this same edge so it stays at 4.
  assign hlt_now = !halted && (phase == PH_OP_ADDR) && (opcode == OP_HLT);
  assign alu     = is_aluop(opcode);

  always_ff @(posedge clk) begin
    if (!rst)
      halted <= 1'b0;
    else if (hlt_now)
      halted <= 1'b1;
  end

  phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .hold  (halted | hlt_now),
    .phase (phase)
  );

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: rd = alu;
        PH_ALU_OP: begin
          rd     = alu;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = alu;
          ld_ac  = alu;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: a reference phase/halt model predicts every cycle's outputs.
module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int checks   = 0;
  int failures = 0;

  int   m_phase;
  logic m_halted;
  logic [11:0] sbq[$];

  always #5 clk = ~clk;

  risc_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode, written per phase from the control table.
  function automatic logic [11:0] model(int ph, logic [2:0] op, logic z, logic hl);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    {s, r, li, ip, lp, la, w, de, h} = '0;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (hl) h = 1'b1;
    else case (ph)
      0: s = 1'b1;
      1: begin s = 1'b1; r = 1'b1; end
      2, 3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
      4: begin ip = 1'b1; h = (op == 3'd0); end
      5: r = alu;
      6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
      7: begin r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); de = (op == 3'd6); end
      default: ;
    endcase
    return {ph[2:0], s, r, li, ip, lp, la, w, de, h};
  endfunction

  // One cycle: drive, predict, compare mid-cycle, advance model on the edge.
  task automatic tick(input logic [2:0] op, input logic z, input logic r);
    logic [11:0] e;
    opcode = op;
    zero   = z;
    rst    = r;
    sbq.push_back(model(m_phase, op, z, m_halted));
    #1;
    e = sbq.pop_front();
    chk($sformatf("ctl op=%0d ph=%0d", op, m_phase),
        {20'd0, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}, {20'd0, e});
    chk("excl_pc", {31'd0, inc_pc & ld_pc}, 32'd0);
    chk("excl_rw", {31'd0, wr & rd}, 32'd0);
    @(posedge clk);
    if (!r) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic z);
    tick(op, z, 1'b0);
    for (int i = 0; i < 8; i++) tick(op, z, 1'b1);
  endtask

  initial begin
    rst    = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_phase  = 0;
    m_halted = 1'b0;
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_halt", {31'd0, halt}, 32'd0);

    run(3'd2, 1'b0);   // ADD
    run(3'd6, 1'b0);   // STO
    run(3'd1, 1'b1);   // SKZ zero=1
    run(3'd1, 1'b0);   // SKZ zero=0
    run(3'd7, 1'b0);   // JMP
    run(3'd3, 1'b1);   // AND
    run(3'd4, 1'b0);   // XOR

    // zero toggling outside phase 6 must not matter
    tick(3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(3'd1, (i != 6), 1'b1);

    // LDA interrupted by reset in phase 6: no ld_ac pulse follows
    tick(3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(3'd5, 1'b0, 1'b1);
    chk("lda_ph6", {29'd0, phase}, 32'd6);
    tick(3'd5, 1'b0, 1'b0);
    chk("lda_rst_ph", {29'd0, phase}, 32'd0);
    chk("lda_no_ldac", {31'd0, ld_ac}, 32'd0);
    for (int i = 0; i < 8; i++) tick(3'd5, 1'b0, 1'b1);

    // HLT: one inc_pc in phase 4, then frozen for 20 cycles despite opcode change
    tick(3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(3'd0, 1'b0, 1'b1);
    chk("hlt_ph", {29'd0, phase}, 32'd4);
    for (int i = 0; i < 20; i++) tick(3'd2, i[0], 1'b1);
    chk("hlt_hold_ph", {29'd0, phase}, 32'd4);
    chk("hlt_hold_halt", {31'd0, halt}, 32'd1);
    chk("hlt_no_inc", {31'd0, inc_pc}, 32'd0);
    tick(3'd2, 1'b0, 1'b0);
    chk("hlt_rst_ph", {29'd0, phase}, 32'd0);
    chk("hlt_rst_halt", {31'd0, halt}, 32'd0);

    // random non-halting traffic with occasional reset
    for (int i = 0; i < 200; i++)
      tick(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), ($urandom_range(15, 0) != 0));

    chk("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
